// File: rtl/spi_slave_rx.sv
// spi_slave_rx: dual-lane SPI receiver, MSB-first on SCK rise while SSEL is low.
// Optional SSEL-low watchdog enabled by SPI_RX_TIMEOUT_EN.
module spi_slave_rx #(
   parameter int NBITS       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 4095
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             SSEL,
   input  logic             SCK,
   input  logic             DATA_IN0,
   input  logic             DATA_IN1,
   output logic [NBITS-1:0] rx_data0,
   output logic [NBITS-1:0] rx_data1,
   output logic             rx_valid,
   output logic             frame_err,
   output logic             busy,
   output logic [15:0]      frame_count
);
   localparam int CW = $clog2(NBITS + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, LOAD, WAIT_END} state_e;
   state_e state_q, state_d;
   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic [1:0] hist_q;
   logic [3:0] s;
   logic ssel_fall, ssel_rise, sck_rise, timeout;
   logic [CW-1:0] bitcnt_q, bitcnt_d;
   logic [NBITS-1:0] sh0_q, sh0_d, sh1_q, sh1_d, rx0_q, rx0_d, rx1_q, rx1_d;
   logic valid_q, valid_d, err_q, err_d;
   logic [15:0] cnt_q, cnt_d;
   // Lanes ride the same chain as SCK so the sampled bit lines up with the detected edge.
   assign s         = sync_q[SYNC_STAGES-1];
   assign ssel_fall = hist_q[1] & ~s[3];
   assign ssel_rise = ~hist_q[1] & s[3];
   assign sck_rise  = ~hist_q[0] & s[2];
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         hist_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], {SSEL, SCK, DATA_IN1, DATA_IN0}};
         hist_q <= s[3:2];
      end
   end
`ifdef SPI_RX_TIMEOUT_EN
   logic [11:0] wd_q;
   assign timeout = wd_q == 12'(TIMEOUT);
   always_ff @(posedge clk) begin
      if (reset) wd_q <= '0;
      else wd_q <= (state_q != SHIFT || sck_rise) ? '0 : wd_q + 12'd1;
   end
`else
   assign timeout = (TIMEOUT < 0);
`endif
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      sh0_d    = sh0_q;
      sh1_d    = sh1_q;
      rx0_d    = rx0_q;
      rx1_d    = rx1_q;
      cnt_d    = cnt_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      if (!en) begin
         state_d  = IDLE;
         bitcnt_d = '0;
         sh0_d    = '0;
         sh1_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d  = ssel_fall ? SHIFT : IDLE;
               bitcnt_d = '0;
            end
            SHIFT: begin
               if (sck_rise) begin
                  sh0_d    = {sh0_q[NBITS-2:0], s[0]};
                  sh1_d    = {sh1_q[NBITS-2:0], s[1]};
                  bitcnt_d = bitcnt_q + CW'(1);
               end
               // A completing edge wins over a simultaneous SSEL rise.
               if (sck_rise && bitcnt_q == CW'(NBITS - 1)) state_d = LOAD;
               else if (ssel_rise) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else if (timeout) begin
                  err_d   = 1'b1;
                  state_d = WAIT_END;
               end
            end
            LOAD: begin
               rx0_d   = sh0_q;
               rx1_d   = sh1_q;
               valid_d = 1'b1;
               cnt_d   = cnt_q + 16'd1;
               state_d = s[3] ? IDLE : WAIT_END;
            end
            WAIT_END: begin
               err_d   = sck_rise;
               state_d = s[3] ? IDLE : WAIT_END;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         sh0_q    <= '0;
         sh1_q    <= '0;
         rx0_q    <= '0;
         rx1_q    <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         sh0_q    <= sh0_d;
         sh1_q    <= sh1_d;
         rx0_q    <= rx0_d;
         rx1_q    <= rx1_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end
   assign rx_data0    = rx0_q;
   assign rx_data1    = rx1_q;
   assign rx_valid    = valid_q;
   assign frame_err   = err_q;
   assign busy        = state_q != IDLE;
   assign frame_count = cnt_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed frames against a frame-level model of the receiver.
module tb_spi_slave_rx;
   localparam int NB = 32, SS = 2, TO = 200;
   logic clk = 0, reset = 1, en = 1, SSEL = 1, SCK = 0, DATA_IN0 = 0, DATA_IN1 = 0;
   logic [NB-1:0] rx_data0, rx_data1;
   logic rx_valid, frame_err, busy;
   logic [15:0] frame_count;
   spi_slave_rx #(.NBITS(NB), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .en(en), .SSEL(SSEL), .SCK(SCK),
      .DATA_IN0(DATA_IN0), .DATA_IN1(DATA_IN1), .rx_data0(rx_data0), .rx_data1(rx_data1),
      .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy), .frame_count(frame_count)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;
   int checks = 0, errors = 0;
   typedef struct {int c; logic [NB-1:0] a; logic [NB-1:0] b;} vev_t;
   vev_t vq[$];
   int eq[$];
   logic [NB-1:0] exp0 = 0, exp1 = 0, m0 = 0, m1 = 0;
   logic [15:0] expc = 0;
   bit mask_err = 0, in_frame = 0, done = 0;
   int nb = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // Frame-level model: events are scheduled from pin activity with fixed pin-to-output latency.
   task automatic m_fall();
      in_frame = 1; done = 0; nb = 0; m0 = 0; m1 = 0;
   endtask
   task automatic m_rise(input logic b0, input logic b1);
      if (!in_frame) return;
      if (done) eq.push_back(cyc + SS + 1);
      else begin
         m0 = (m0 << 1) | NB'(b0);
         m1 = (m1 << 1) | NB'(b1);
         nb++;
         if (nb == NB) begin
            vq.push_back('{c: cyc + SS + 2, a: m0, b: m1});
            done = 1;
         end
      end
   endtask
   task automatic m_ssel_rise();
      if (in_frame && !done) eq.push_back(cyc + SS + 1);
      in_frame = 0; done = 0;
   endtask
   initial begin
      bit ve, ee;
      forever begin
         @(posedge clk);
         #2;
         ve = vq.size() > 0 && vq[0].c == cyc;
         ee = eq.size() > 0 && eq[0] == cyc;
         if (ve) begin
            exp0 = vq[0].a; exp1 = vq[0].b; expc = expc + 16'd1;
            void'(vq.pop_front());
         end
         if (ee) void'(eq.pop_front());
         chk("rx_valid", rx_valid, ve);
         if (!mask_err) chk("frame_err", frame_err, ee);
         chk("rx_data0", rx_data0, exp0);
         chk("rx_data1", rx_data1, exp1);
         chk("frame_count", frame_count, expc);
         chk("valid_err_excl", rx_valid & frame_err, 0);
      end
   end
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic ssel_lo();
      SSEL = 0; m_fall(); tick(8);
   endtask
   task automatic ssel_hi();
      SSEL = 1; m_ssel_rise(); tick(8);
   endtask
   task automatic pulse(input logic b0, input logic b1);
      DATA_IN0 = b0; DATA_IN1 = b1;
      tick(8);
      SCK = 1; m_rise(b0, b1);
      tick(8);
      SCK = 0;
   endtask
   task automatic bits(input logic [NB-1:0] w0, input logic [NB-1:0] w1, input int n);
      for (int i = 0; i < n; i++) begin
         pulse(w0[NB-1], w1[NB-1]);
         w0 = w0 << 1; w1 = w1 << 1;
      end
   endtask
   task automatic frame(input logic [NB-1:0] w0, input logic [NB-1:0] w1);
      ssel_lo(); bits(w0, w1, NB); ssel_hi();
   endtask
   task automatic do_reset(input int n);
      reset = 1;
      vq.delete(); eq.delete();
      exp0 = 0; exp1 = 0; expc = 0; in_frame = 0; done = 0;
      tick(n);
      reset = 0;
   endtask
   initial begin
      int n;
      @(negedge clk);
      do_reset(4);
      tick(6);
      chk("reset_busy", busy, 0);
      chk("reset_data0", rx_data0, 0);
      chk("reset_count", frame_count, 0);
      frame(32'hDEADBEEF, 32'h12345678);
      chk("t2_data0", rx_data0, 32'hDEADBEEF);
      chk("t2_data1", rx_data1, 32'h12345678);
      chk("t2_count", frame_count, 1);
      ssel_lo(); bits(32'hCAFEF00D, 32'h0F0F0F0F, 20); ssel_hi();
      chk("t3_busy", busy, 0);
      chk("t3_data0", rx_data0, 32'hDEADBEEF);
      ssel_lo(); bits(32'h11223344, 32'h55667788, 33); ssel_hi();
      chk("t4_data0", rx_data0, 32'h11223344);
      chk("t4_data1", rx_data1, 32'h55667788);
      chk("t4_count", frame_count, 2);
      ssel_lo(); bits(32'hFFFFFFFF, 32'h0, 10);
      do_reset(1);
      ssel_hi();
      frame(32'hA5A5A5A5, 32'h5A5A5A5A);
      chk("t5_data0", rx_data0, 32'hA5A5A5A5);
      chk("t5_data1", rx_data1, 32'h5A5A5A5A);
      chk("t5_count", frame_count, 1);
      ssel_lo(); bits(32'h87654321, 32'h13579BDF, 5);
      en = 0; in_frame = 0;
      tick(4);
      chk("en_busy", busy, 0);
      en = 1;
      bits(32'hFFFFFFFF, 32'hFFFFFFFF, 6);
      chk("en_ssel_low_busy", busy, 0);
      ssel_hi();
      chk("en_count", frame_count, 1);
      ssel_lo(); bits(32'h3C3C3C3C, 32'hC3C3C3C3, NB - 1);
      DATA_IN0 = 0; DATA_IN1 = 1;
      tick(8);
      SCK = 1; SSEL = 1; m_rise(0, 1); m_ssel_rise();
      tick(8); SCK = 0; tick(8);
      chk("same_edge_busy", busy, 0);
      chk("same_edge_data0", rx_data0, 32'h3C3C3C3C);
      chk("same_edge_data1", rx_data1, 32'hC3C3C3C3);
      force dut.cnt_q = 16'hFFFF;
      expc = 16'hFFFF;
      tick(1);
      release dut.cnt_q;
      tick(1);
      frame(32'h01020304, 32'h05060708);
      chk("wrap_count", frame_count, 0);
      ssel_lo(); bits(32'hF0000000, 32'h0F000000, 5);
      mask_err = 1; n = 0;
      repeat (TO + 12) begin
         @(negedge clk);
         if (frame_err) n++;
      end
`ifdef SPI_RX_TIMEOUT_EN
      chk("timeout_pulses", n, 1);
      done = 1;
`else
      chk("timeout_pulses", n, 0);
`endif
      chk("timeout_busy", busy, 1);
      mask_err = 0;
      ssel_hi();
      chk("timeout_end_busy", busy, 0);
      tick(10);
      chk("pending_events", vq.size() + eq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
